// File: rtl/mips32_pkg.sv
// Shared mips32 definitions: arbiter state/owner encodings, bus-width defaults
// and the instruction opcode/type constants used across the pipeline.
package mips32_pkg;

  localparam int AW_DEF = 10;
  localparam int DW_DEF = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HLT   = 6'h3F;

  typedef enum logic [2:0] {
    RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT
  } instr_type_e;

  typedef enum logic {OWN_IF, OWN_DM} owner_e;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} arb_state_e;

endpackage

// File: rtl/mips32_mem_arbiter_if.sv
// Fetch, data and memory-array signals of the unified memory arbiter.
// master = the arbiter's view; slave = the pipeline/memory side.
interface mips32_mem_arbiter_if #(
  parameter int AW = mips32_pkg::AW_DEF,
  parameter int DW = mips32_pkg::DW_DEF
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic          dm_rvalid;
  logic [DW-1:0] dm_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mips32_arb_prio.sv
// Winner select for the memory arbiter: data beats fetch unless fetch has
// watched STARVE_MAX data grants go by, in which case fetch is forced through.
module mips32_arb_prio #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk1,
  input  logic rst,
  input  logic idle,
  input  logic halted,
  input  logic flush,
  input  logic if_req,
  input  logic dm_req,
  output logic if_win,
  output logic dm_win
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_SAT = SW'(STARVE_MAX);

  logic [SW-1:0] starve_q, starve_d;
  logic          grant_ok, if_elig, if_forced;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    grant_ok  = idle && !halted && !rst;
    if_elig   = if_req && !flush;
    if_forced = if_elig && (starve_q == STARVE_SAT);
    if_win    = grant_ok && if_elig && (if_forced || !dm_req);
    dm_win    = grant_ok && dm_req && !if_forced;

    starve_d = starve_q;
    if (if_win || (idle && !if_req)) begin
      starve_d = '0;
    end else if (dm_win && if_req && (starve_q != STARVE_SAT)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // NOTE: synchronous reset is tested inside the clocked block, and state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk1) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Shares one fixed-latency memory between fetch and the MEM-stage port:
// IDLE grants one access, WAIT counts the memory latency, RESP strobes rvalid.
module mips32_mem_arbiter
  import mips32_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk1,
  input  logic                 rst,
  input  logic                 halted,
  input  logic                 flush,
  mips32_mem_arbiter_if.master bus
);
  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [LW-1:0] LAT_INIT = LW'(MEM_LAT - 1);

  arb_state_e    state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [LW-1:0] lat_q, lat_d;
  logic          cancel_q, cancel_d;
  logic          we_q, we_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;
  logic          if_win, dm_win;
  logic [AW-1:0] addr_sel;

  mips32_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .clk1   (clk1),
    .rst    (rst),
    .idle   (state_q == IDLE),
    .halted (halted),
    .flush  (flush),
    .if_req (bus.if_req),
    .dm_req (bus.dm_req),
    .if_win (if_win),
    .dm_win (dm_win)
  );

  // The memory strobes exist only in the grant cycle and follow the winner.
  always_comb begin
    addr_sel = '0;
    if (dm_win)      addr_sel = bus.dm_addr;
    else if (if_win) addr_sel = bus.if_addr;
  end

  assign bus.if_gnt    = if_win;
  assign bus.dm_gnt    = dm_win;
  assign bus.mem_en    = if_win || dm_win;
  assign bus.mem_we    = dm_win && bus.dm_we;
  assign bus.mem_addr  = addr_sel;
  assign bus.mem_wdata = (dm_win && bus.dm_we) ? bus.dm_wdata : '0;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    lat_d      = lat_q;
    cancel_d   = cancel_q;
    we_d       = we_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (if_win || dm_win) begin
          state_d  = WAIT;
          owner_d  = dm_win ? OWN_DM : OWN_IF;
          we_d     = dm_win && bus.dm_we;
          lat_d    = LAT_INIT;
          cancel_d = 1'b0;
        end
      end
      WAIT: begin
        if (owner_q == OWN_IF && flush) cancel_d = 1'b1;
        if (lat_q == '0) begin
          state_d = RESP;
          if (owner_q == OWN_DM) dm_rdata_d = we_q ? '0 : bus.mem_rdata;
          else                   if_rdata_d = bus.mem_rdata;
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      lat_q      <= '0;
      cancel_q   <= 1'b0;
      we_q       <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      lat_q      <= lat_d;
      cancel_q   <= cancel_d;
      we_q       <= we_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  // A flush landing in the response cycle itself still kills the wrong-path fetch.
  assign bus.if_rvalid = (state_q == RESP) && (owner_q == OWN_IF) && !cancel_q && !flush;
  assign bus.dm_rvalid = (state_q == RESP) && (owner_q == OWN_DM);
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Directed bench for mips32_mem_arbiter with a 2-cycle-latency memory model.
module tb_mips32_mem_arbiter;

  logic clk1 = 1'b0;
  logic rst, halted, flush;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk1 = ~clk1;

  mips32_mem_arbiter_if #(.AW(10), .DW(32)) bus ();

  mips32_mem_arbiter #(.AW(10), .DW(32), .MEM_LAT(2), .STARVE_MAX(4)) dut (
    .clk1   (clk1),
    .rst    (rst),
    .halted (halted),
    .flush  (flush),
    .bus    (bus)
  );

  function automatic logic [31:0] init_word(input logic [9:0] a);
    return (a == 10'd5) ? 32'h2801_000A : (32'hA5A5_0000 | {22'd0, a});
  endfunction

  // Memory model: data appears on mem_rdata two cycles after mem_en.
  logic [31:0] mem [1024];
  logic [31:0] rd1 = '0, rd2 = '0;
  logic        loaded = 1'b0;

  always @(posedge clk1) begin
    if (!loaded) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_word(10'(i));
      loaded <= 1'b1;
    end else if (bus.mem_en) begin
      rd1 <= mem[bus.mem_addr];
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    end else begin
      rd1 <= '0;
    end
    rd2 <= rd1;
  end
  assign bus.mem_rdata = rd2;

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_bit ({tag, "_if_gnt"},    bus.if_gnt,    1'b0);
    check_bit ({tag, "_dm_gnt"},    bus.dm_gnt,    1'b0);
    check_bit ({tag, "_if_rvalid"}, bus.if_rvalid, 1'b0);
    check_bit ({tag, "_dm_rvalid"}, bus.dm_rvalid, 1'b0);
    check_word({tag, "_if_rdata"},  bus.if_rdata,  32'h0);
    check_word({tag, "_dm_rdata"},  bus.dm_rdata,  32'h0);
    check_bit ({tag, "_mem_en"},    bus.mem_en,    1'b0);
    check_bit ({tag, "_mem_we"},    bus.mem_we,    1'b0);
    check_word({tag, "_mem_addr"},  32'(bus.mem_addr), 32'h0);
    check_word({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0);
  endtask

  typedef struct packed {
    bit          is_dm;
    bit          we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];

  // One uncontested access: grant now, response strobe exactly three cycles later.
  task automatic run_single(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk1);
    bus.if_req   = !v.is_dm;
    bus.dm_req   = v.is_dm;
    bus.dm_we    = v.we;
    bus.if_addr  = v.addr;
    bus.dm_addr  = v.addr;
    bus.dm_wdata = v.wdata;
    #1;
    check_bit ({tag, "_if_gnt"},    bus.if_gnt, !v.is_dm);
    check_bit ({tag, "_dm_gnt"},    bus.dm_gnt, v.is_dm);
    check_bit ({tag, "_mem_en"},    bus.mem_en, 1'b1);
    check_word({tag, "_mem_addr"},  32'(bus.mem_addr), 32'(v.addr));
    check_bit ({tag, "_mem_we"},    bus.mem_we, v.is_dm && v.we);
    check_word({tag, "_mem_wdata"}, bus.mem_wdata, (v.is_dm && v.we) ? v.wdata : 32'h0);
    check_bit ({tag, "_rv_quiet"},  bus.if_rvalid || bus.dm_rvalid, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk1);
      bus.if_req = 1'b0;
      bus.dm_req = 1'b0;
      bus.dm_we  = 1'b0;
      #1;
      check_bit ({tag, "_busy_mem_en"}, bus.mem_en, 1'b0);
      check_bit ({tag, "_if_rvalid"},   bus.if_rvalid, (k == 3) && !v.is_dm);
      check_bit ({tag, "_dm_rvalid"},   bus.dm_rvalid, (k == 3) && v.is_dm);
      if (k == 3) begin
        if (v.is_dm) check_word({tag, "_dm_rdata"}, bus.dm_rdata, v.exp_rdata);
        else         check_word({tag, "_if_rdata"}, bus.if_rdata, v.exp_rdata);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] exp_if_win;
    int         gcount, last_c;

    vecs[0] = '{1'b0, 1'b0, 10'h005, 32'h0,         32'h2801_000A};
    vecs[1] = '{1'b1, 1'b1, 10'h03F, 32'hDEAD_BEEF, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 10'h03F, 32'h0,         32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 1'b0, 10'h020, 32'h0,         32'hA5A5_0020};
    vecs[4] = '{1'b0, 1'b0, 10'h3FF, 32'h0,         32'hA5A5_03FF};
    vecs[5] = '{1'b1, 1'b1, 10'h000, 32'h1234_5678, 32'h0};
    vecs[6] = '{1'b1, 1'b0, 10'h000, 32'h0,         32'h1234_5678};

    rst = 1'b1; halted = 1'b0; flush = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;

    // Reset state, requests pending while in reset must not be granted.
    repeat (3) @(negedge clk1);
    bus.if_req = 1'b1; bus.dm_req = 1'b1;
    #1;
    check_all_zero("reset");
    bus.if_req = 1'b0; bus.dm_req = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_single(i, vecs[i]);

    // Simultaneous requests: data first, fetch granted right after data completes.
    @(negedge clk1);
    bus.if_req = 1'b1; bus.if_addr = 10'd7;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 10'h020;
    #1;
    check_bit ("both_dm_gnt", bus.dm_gnt, 1'b1);
    check_bit ("both_if_gnt", bus.if_gnt, 1'b0);
    check_word("both_mem_addr", 32'(bus.mem_addr), 32'h20);
    @(negedge clk1); bus.dm_req = 1'b0;
    @(negedge clk1);
    @(negedge clk1); #1;
    check_bit ("both_dm_rvalid", bus.dm_rvalid, 1'b1);
    check_word("both_dm_rdata",  bus.dm_rdata, 32'hA5A5_0020);
    check_bit ("both_if_wait",   bus.if_gnt, 1'b0);
    @(negedge clk1); #1;
    check_bit ("both_if_gnt_c5",  bus.if_gnt, 1'b1);
    check_word("both_if_addr_c5", 32'(bus.mem_addr), 32'd7);
    @(negedge clk1); bus.if_req = 1'b0;
    @(negedge clk1);
    @(negedge clk1); #1;
    check_bit ("both_if_rvalid", bus.if_rvalid, 1'b1);
    check_word("both_if_rdata",  bus.if_rdata, 32'hA5A5_0007);

    // Starvation guard: four data grants, then fetch, then data again.
    exp_if_win = 7'b001_0000;
    gcount = 0; last_c = 0;
    bus.if_addr = 10'd11; bus.dm_addr = 10'h024; bus.dm_we = 1'b0;
    for (int c = 0; c < 40 && gcount < 7; c++) begin
      @(negedge clk1);
      bus.if_req = 1'b1; bus.dm_req = 1'b1;
      #1;
      if (bus.if_gnt || bus.dm_gnt) begin
        check_bit($sformatf("starve_if_win%0d", gcount), bus.if_gnt, exp_if_win[gcount]);
        if (gcount > 0) check_word($sformatf("starve_gap%0d", gcount), 32'(c - last_c), 32'd4);
        last_c = c;
        gcount++;
      end
    end
    check_word("starve_grants", 32'(gcount), 32'd7);
    @(negedge clk1); bus.if_req = 1'b0; bus.dm_req = 1'b0;
    repeat (3) @(negedge clk1);

    // Flush during a fetch cancels its response; the FSM timing is unchanged.
    @(negedge clk1);
    bus.if_req = 1'b1; bus.if_addr = 10'd9;
    #1; check_bit("flush_if_gnt", bus.if_gnt, 1'b1);
    @(negedge clk1); bus.if_req = 1'b0; flush = 1'b1;
    @(negedge clk1); flush = 1'b0;
    #1; check_bit("flush_c3_rvalid", bus.if_rvalid, 1'b0);
    @(negedge clk1); #1;
    check_bit("flush_cancel", bus.if_rvalid, 1'b0);
    @(negedge clk1); bus.if_req = 1'b1;
    #1; check_bit("flush_regrant", bus.if_gnt, 1'b1);
    @(negedge clk1); bus.if_req = 1'b0;
    @(negedge clk1);
    @(negedge clk1); #1;
    check_bit ("flush_after_rvalid", bus.if_rvalid, 1'b1);
    check_word("flush_after_rdata",  bus.if_rdata, 32'hA5A5_0009);

    // Flush in IDLE: fetch ineligible, data still wins; flush ignored for data owner.
    @(negedge clk1);
    bus.if_req = 1'b1; flush = 1'b1;
    #1;
    check_bit("idle_flush_if_gnt", bus.if_gnt, 1'b0);
    check_bit("idle_flush_mem_en", bus.mem_en, 1'b0);
    @(negedge clk1);
    bus.dm_req = 1'b1; bus.dm_addr = 10'h025; bus.dm_we = 1'b0;
    #1;
    check_bit("idle_flush_dm_gnt", bus.dm_gnt, 1'b1);
    check_bit("idle_flush_if_no",  bus.if_gnt, 1'b0);
    @(negedge clk1); bus.dm_req = 1'b0; bus.if_req = 1'b0;
    @(negedge clk1);
    @(negedge clk1); #1;
    check_bit ("dm_flush_rvalid", bus.dm_rvalid, 1'b1);
    check_word("dm_flush_rdata",  bus.dm_rdata, 32'hA5A5_0025);
    flush = 1'b0;

    // Halt: in-flight load completes, no new grants until released.
    @(negedge clk1);
    bus.dm_req = 1'b1; bus.dm_addr = 10'h021;
    #1; check_bit("halt_dm_gnt", bus.dm_gnt, 1'b1);
    @(negedge clk1);
    bus.dm_req = 1'b0; halted = 1'b1; bus.if_req = 1'b1; bus.if_addr = 10'h030;
    @(negedge clk1);
    @(negedge clk1); #1;
    check_bit ("halt_dm_rvalid", bus.dm_rvalid, 1'b1);
    check_word("halt_dm_rdata",  bus.dm_rdata, 32'hA5A5_0021);
    @(negedge clk1); #1;
    check_bit("halt_no_if_gnt", bus.if_gnt, 1'b0);
    check_bit("halt_no_mem_en", bus.mem_en, 1'b0);
    @(negedge clk1); bus.dm_req = 1'b1;
    #1;
    check_bit("halt_no_dm_gnt",  bus.dm_gnt, 1'b0);
    check_bit("halt_no_mem_en2", bus.mem_en, 1'b0);
    @(negedge clk1); halted = 1'b0; bus.dm_req = 1'b0;
    #1;
    check_bit ("unhalt_if_gnt",  bus.if_gnt, 1'b1);
    check_word("unhalt_if_addr", 32'(bus.mem_addr), 32'h30);
    @(negedge clk1); bus.if_req = 1'b0;
    @(negedge clk1);
    @(negedge clk1); #1;
    check_bit ("unhalt_if_rvalid", bus.if_rvalid, 1'b1);
    check_word("unhalt_if_rdata",  bus.if_rdata, 32'hA5A5_0030);

    // Reset in the middle of a load discards its response.
    @(negedge clk1);
    bus.dm_req = 1'b1; bus.dm_addr = 10'h022;
    #1; check_bit("rst_dm_gnt", bus.dm_gnt, 1'b1);
    @(negedge clk1); bus.dm_req = 1'b0; rst = 1'b1;
    @(negedge clk1); rst = 1'b0;
    #1; check_all_zero("midrst");
    @(negedge clk1);
    bus.dm_req = 1'b1; bus.dm_addr = 10'h023;
    #1;
    check_bit("midrst_no_rvalid", bus.dm_rvalid, 1'b0);
    check_bit("post_rst_dm_gnt",  bus.dm_gnt, 1'b1);
    @(negedge clk1); bus.dm_req = 1'b0;
    @(negedge clk1);
    @(negedge clk1); #1;
    check_bit ("post_rst_rvalid", bus.dm_rvalid, 1'b1);
    check_word("post_rst_rdata",  bus.dm_rdata, 32'hA5A5_0023);

    @(negedge clk1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
